div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider shared by the EX stage for DIV/DIVU.
//  EX drives start/operands and holds pauseRequest until success_o.
//  The result returns as {remainder, quotient}, which EX writes straight into {HI, LO}.
//  annul_i cancels an in-flight divide on a pipeline flush or exception.
// PARAMETERS
//  WIDTH  32  operand width; only 32 is verified; iteration count = WIDTH
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset: synchronous, active-high
//  signed_i    in   1   1 = DIV (two's complement), 0 = DIVU
//  dividend_i  in   32  dividend; sampled only on start acceptance
//  divider_i   in   32  divisor; sampled only on start acceptance
//  start_i     in   1   level request; held high by EX until it sees success_o
//  annul_i     in   1   cancel current operation; returns to IDLE
//  result_o    out  64  {remainder[31:0], quotient[31:0]}; valid while success_o=1
//  success_o   out  1   result valid
//  busy_o      out  1   high in DIVZERO and ON states
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): state=IDLE; result_o=0, success_o=0, busy_o=0; counter and working regs = 0.
//   Reset has priority over every other input, including in mid-operation.
//  Outputs are registered; no combinational path from inputs to outputs.
//  States:
//   IDLE: on start_i=1 && annul_i=0:
//    - divider_i==0 -> DIVZERO;
//    - else -> ON; latch operands, cnt=0.
//    If signed_i=1, latch |dividend| and |divisor|, and store sign flags of the dividend and of the divisor.
//    Otherwise remain in IDLE; success_o=0, result_o=0.
//   DIVZERO: next edge -> END with result_o=0. success_o=1 two edges after acceptance.
//   ON: one iteration per edge; after WIDTH iterations -> END.
//    - partial = {rem[31:0], quo[31]} (33 bits); diff = partial - {1'b0, dvsr}.
//    - diff[32]==0: rem <= diff[31:0], quo <= {quo[30:0], 1}.
//    - else: rem <= partial[31:0], quo <= {quo[30:0], 0}.
//    - cnt increments 0..31; the edge with cnt==31 writes the final values and enters END.
//   END: result_o registered, success_o=1.
//    success_o first high 33 edges after the accepting edge (accept edge = E0, success after E0+33).
//    Stay in END while start_i=1; result_o stable.
//    start_i=0 -> IDLE; success_o=0 and result_o=0 on that edge.
//  Signed fix-up on entry to END:
//   - quotient negated if dividend sign != divisor sign;
//   - remainder negated if dividend negative.
//   - 0x80000000 / 0xFFFFFFFF wraps: quotient 0x80000000, remainder 0.
//  annul_i=1 in DIVZERO or ON: -> IDLE next edge; success_o stays 0; partial result discarded.
//   annul_i in END: -> IDLE, success_o=0.
//   annul_i and start_i both high in IDLE: stay IDLE (annul wins).
//  Operand changes after acceptance are ignored.
//  A new start is only accepted from IDLE, so at least one idle cycle separates back-to-back divides.
// TESTING
//  1. Unsigned 100/7 -> success_o high after E0+33; result_o={32'd2, 32'd14}; busy_o high E0+1..E0+33.
//  2. Signed -7/2 (0xFFFFFFF9, 0x2) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}.
//     Unsigned same operands -> {0x1, 0x7FFFFFFC}.
//  3. Divide by zero (any dividend, 0) -> success_o after E0+2; result_o=64'h0.
//  4. annul_i pulsed at E0+10 -> IDLE at E0+11; success_o never rises.
//     Next start is accepted normally and yields the correct result.
//  5. Hold start_i 5 extra cycles in END -> result_o stable.
//     Drop start_i -> success_o=0 and result_o=0 next edge.
//     Signed 0x80000000/0xFFFFFFFF -> {0x0, 0x80000000}.
//  6. rst asserted at E0+20 -> all outputs 0, IDLE next edge; fresh 9/3 -> {0, 3}.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider returning {remainder, quotient}
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divider_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 success_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIVZERO = 2'd1;
    localparam logic [1:0] ON      = 2'd2;
    localparam logic [1:0] END     = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_quo;
    logic             neg_rem;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        dividend_neg = signed_i & dividend_i[WIDTH-1];
        divisor_neg  = signed_i & divider_i[WIDTH-1];
        abs_dividend = dividend_neg ? -dividend_i : dividend_i;
        abs_divisor  = divisor_neg ? -divider_i : divider_i;
        // quo doubles as the dividend shift register: its MSB feeds the partial remainder
        partial      = {rem, quo[WIDTH-1]};
        diff         = partial - {1'b0, dvsr};
        quo_fix      = neg_quo ? -quo : quo;
        rem_fix      = neg_rem ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            result_o  <= '0;
            success_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            success_o <= 1'b0;
            result_o  <= '0;
            busy_o    <= (state == ON) || (state == DIVZERO);
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        cnt <= '0;
                        rem <= '0;
                        if (divider_i == '0) begin
                            state   <= DIVZERO;
                            quo     <= '0;
                            dvsr    <= '0;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                        end else begin
                            state   <= ON;
                            quo     <= abs_dividend;
                            dvsr    <= abs_divisor;
                            neg_quo <= dividend_neg ^ divisor_neg;
                            neg_rem <= dividend_neg;
                        end
                    end
                end
                DIVZERO: begin
                    state <= annul_i ? IDLE : END;
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        if (!diff[WIDTH]) begin
                            rem <= diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= partial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= END;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state <= IDLE;
                    end else begin
                        success_o <= 1'b1;
                        result_o  <= {rem_fix, quo_fix};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
